// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the memory responder: FSM state encoding, the
//   word size and the address error check used by the top level.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int WORD_BYTES = 4;

  // An access is in error when it is not word aligned, or when any address
  // bit above the implemented word index (bits aw+1..2) is set.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    logic hi_set;
    hi_set = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ((i >= aw + 2) && addr[i]) hi_set = 1'b1;
    end
    return (addr[1:0] != 2'b00) | hi_set;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array
//   Single-port word RAM, DEPTH_WORDS x 32, synchronous write and
//   combinational read. Contents are never reset.
//   Ports:
//     clk    in   clock, rising edge
//     we     in   write enable for idx on this edge
//     idx    in   word index
//     wdata  in   write data
//     rdata  out  current contents of word idx
module mem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  import mem_responder_pkg::*;

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle CPU's unified memory port.
//   One word request is accepted at a time over valid/ready; a single-cycle
//   response strobe follows LATENCY+1 cycles after the accept edge.
//   Ports:
//     clk         in   clock, rising edge
//     reset       in   synchronous active-high reset
//     req_valid   in   request present
//     req_ready   out  high only while idle
//     req_we      in   1 = write, 0 = read
//     req_addr    in   byte address
//     req_wdata   in   write data
//     resp_valid  out  one-cycle response strobe
//     resp_rdata  out  read data (0 for writes and errors), held between responses
//     resp_err    out  misaligned / out-of-range flag, held between responses
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  import mem_responder_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic          mem_we;
  logic [31:0]   mem_rdata;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    err_d        = err_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          err_d   = addr_err(req_addr, AW);
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          // WAIT always lasts LATENCY cycles (also for LATENCY==1) so the
          // response lands LATENCY+1 cycles after the accept edge.
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_COMMIT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_COMMIT: begin
        // Reset in this cycle must keep the write out of the array.
        mem_we       = we_q & ~err_q & ~reset;
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = (we_q | err_q) ? 32'h0 : mem_rdata;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Ready is decoded from state only; no path from req_valid.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives two responders (LATENCY=2 and LATENCY=1) against a word-array
//   reference model: directed scenarios followed by random traffic.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk        (clk),
    .reset      (reset[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .resp_valid (resp_valid[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk        (clk),
    .reset      (reset[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .resp_valid (resp_valid[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [2][DEPTH];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: wait for ready, present the request for one edge,
  // then watch every cycle up to the return to IDLE.
  task automatic do_req(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
    int          n;
    int          lat;
    bit          e;
    logic [31:0] exp_rd;
    lat    = lat_of(d);
    e      = exp_err(addr);
    exp_rd = (we || e) ? 32'h0 : model[d][int'(addr >> 2)];
    @(negedge clk);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_idle"}, {31'b0, req_ready[d]}, 32'd1);
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = data;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    chk({tag, "_ready_busy"}, {31'b0, req_ready[d]}, 32'd0);
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, {31'b0, resp_valid[d]}, {31'b0, (k == lat + 1)});
      chk({tag, "_ready"}, {31'b0, req_ready[d]}, {31'b0, (k == lat + 2)});
      if (k >= lat + 1) begin
        chk({tag, "_rdata"}, resp_rdata[d], exp_rd);
        chk({tag, "_err"}, {31'b0, resp_err[d]}, {31'b0, e});
      end
    end
    if (we && !e) model[d][int'(addr >> 2)] = data;
    $display("dut%0d %s we=%0d addr=%h wdata=%h rdata=%h err=%0d", d, tag, we, addr, data,
             exp_rd, e);
  endtask

  initial begin
    int          pulses;
    int          wide;
    int          low_cnt;
    bit          prev;
    logic [31:0] a;
    logic [31:0] old_val;
    int          r;

    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    // Requests presented together with reset must not be accepted.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", {31'b0, req_ready[d]}, 32'd1);
      chk("reset_valid", {31'b0, resp_valid[d]}, 32'd0);
      chk("reset_rdata", resp_rdata[d], 32'd0);
      chk("reset_err", {31'b0, resp_err[d]}, 32'd0);
    end

    // Give every word a known value so any read has a defined expectation.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        do_req(d, 1'b1, 32'(i * 4), $urandom, "fill");

    // Basic write/read
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    do_req(0, 1'b0, 32'h10, 32'h0, "rd10");
    // Misaligned
    do_req(0, 1'b0, 32'h12, 32'h0, "rd12_mis");
    do_req(0, 1'b1, 32'h3, 32'hCAFEF00D, "wr03_mis");
    do_req(0, 1'b0, 32'h0, 32'h0, "rd00");
    // Out of range and top word
    do_req(0, 1'b0, 32'h100, 32'h0, "rd100_oor");
    do_req(0, 1'b1, 32'h8000_0010, 32'h11111111, "wr_hi_oor");
    do_req(0, 1'b1, 32'hFC, 32'h0BADCAFE, "wrFC");
    do_req(0, 1'b0, 32'hFC, 32'h0, "rdFC");

    // req_valid held high across four reads
    a = 32'($urandom_range(0, DEPTH - 1) * 4);
    @(negedge clk);
    chk("stream_ready0", {31'b0, req_ready[0]}, 32'd1);
    req_we[0]    = 1'b0;
    req_addr[0]  = a;
    req_valid[0] = 1'b1;
    pulses  = 0;
    wide    = 0;
    low_cnt = 0;
    prev    = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 3 * (LAT0 + 3)) req_valid[0] = 1'b0;
      if (req_ready[0] === 1'b0) low_cnt++;
      if (resp_valid[0] === 1'b1) begin
        pulses++;
        if (prev) wide++;
        chk("stream_rdata", resp_rdata[0], model[0][int'(a >> 2)]);
      end
      prev = (resp_valid[0] === 1'b1);
    end
    chk("stream_pulses", 32'(pulses), 32'd4);
    chk("stream_wide", 32'(wide), 32'd0);
    chk("stream_busy_cycles", 32'(low_cnt), 32'(4 * (LAT0 + 2)));
    $display("dut0 stream 4 reads addr=%h pulses=%0d", a, pulses);

    // Reset during WAIT abandons a write
    a       = 32'h40;
    old_val = model[0][int'(a >> 2)];
    @(negedge clk);
    req_we[0]    = 1'b1;
    req_addr[0]  = a;
    req_wdata[0] = 32'h1234;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req_ready[0]}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("rst_mid_novalid", {31'b0, resp_valid[0]}, 32'd0);
      @(negedge clk);
    end
    $display("dut0 reset during write addr=%h old=%h", a, old_val);
    do_req(0, 1'b0, a, 32'h0, "rd_after_rst");

    // LATENCY=1 instance, back-to-back write then read
    do_req(1, 1'b1, 32'h20, 32'hA5, "l1_wr20");
    do_req(1, 1'b0, 32'h20, 32'h0, "l1_rd20");

    // Random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 30; t++) begin
        r = int'($urandom_range(0, 9));
        if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else             a = $urandom | 32'h0000_0100;
        do_req(d, 1'($urandom_range(0, 1)), a, $urandom, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
